perip_laser_array: RTL
======================

PERIP_LASER_ARRAY -- requirements
Module: perip_laser_array

Interface
REQ-001 SHALL have parameter NCH, default 4, number of laser channels (legal range 1..16).
REQ-002 SHALL have parameter DEB_CYCLES, default 1000, debounce length in clk cycles (>=1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, 2..64).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port d_in  input  32  bus write data.
REQ-007 SHALL have port cs  input  1  peripheral select.
REQ-008 SHALL have port addr  input  32  byte address; only addr[4:0] decoded.
REQ-009 SHALL have port rd  input  1  read strobe, qualified by cs.
REQ-010 SHALL have port wr  input  1  write strobe, qualified by cs.
REQ-011 SHALL have port d_out  output  32  registered read data.
REQ-012 SHALL have port laser  input  NCH  asynchronous raw laser-break inputs.
REQ-013 SHALL have port irq  output  1  registered level interrupt.

Function
REQ-014 SHALL pass each laser bit through a 2-flop synchroniser before any other use.
REQ-015 SHALL debounce per channel: debounced level takes the synchronised value only after it differs from the current debounced level for DEB_CYCLES consecutive cycles; any intervening match clears that channel's counter.
REQ-016 SHALL detect a rise on a channel in the cycle its debounced level goes 0->1; only channels with CTRL enable bit set generate rises.
REQ-017 SHALL decode registers: 0x00 LEVEL (R, [NCH-1:0] debounced levels); 0x04 RISE (R, latched rises; W1C); 0x08 CTRL (R/W, [NCH-1:0] enable mask, bit31 irq enable); 0x0C EVENT (R, pops FIFO); 0x10 STAT (R, [6:0] FIFO count, bit8 overflow; write bit8=1 clears overflow).
REQ-018 SHALL update d_out one cycle after cs&&rd with the addressed register; unused bits read 0; unmapped addresses read 0; d_out holds its value when no read occurs.
REQ-019 SHALL ignore writes to read-only registers and unmapped addresses; cs&&rd&&wr together performs both.
REQ-020 SHALL push one FIFO entry (NCH-bit rise mask) in any cycle with at least one rise; multiple simultaneous rises share one entry.
REQ-021 SHALL return on EVENT read {bit31 valid, [NCH-1:0] mask} of the head entry and pop it; when empty return 0 and pop nothing.
REQ-022 SHALL on push while full (with no pop that cycle) drop the new entry and set sticky overflow; push and pop in the same cycle when full SHALL succeed without overflow.
REQ-023 SHALL on push and EVENT read in the same cycle while empty return 0 and retain the pushed entry.
REQ-024 SHALL give a new rise priority over a same-cycle W1C of the same RISE bit (bit stays 1).
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-026 SHALL drive irq = CTRL[31] && (FIFO count != 0 || overflow), registered, one cycle after the condition.

Reset
REQ-027 SHALL on rst clear synchroniser flops, debounce counters, debounced levels, RISE, CTRL, FIFO pointers/count, overflow, d_out and irq to 0, overriding any same-cycle bus access, including mid-debounce or mid-read.

Verification
REQ-028 SHALL cover: DEB_CYCLES=4, CTRL=0xF, laser[1] high for 3 cycles then low -> LEVEL stays 0, FIFO count 0.
REQ-029 SHALL cover: laser[0] and laser[2] rise same cycle, held -> after 2+4 cycles one FIFO entry; EVENT read returns 0x80000005, STAT count then 0.
REQ-030 SHALL cover: FIFO_DEPTH=8, 9 rise events with no reads -> STAT reads 0x108; write 0x100 to STAT -> reads 0x008.
REQ-031 SHALL cover: RISE=0x2, write 0x2 to RISE same cycle channel 1 rises again -> RISE reads 0x2; a later write 0x2 -> reads 0x0.
REQ-032 SHALL cover: CTRL=0x80000001, channel 0 rise -> irq 1; EVENT read empties FIFO -> irq 0 next cycle; EVENT read on empty -> 0x00000000.
REQ-033 SHALL cover: rst asserted with 3 FIFO entries and a pending read -> next cycle d_out, irq, STAT, LEVEL, CTRL all 0.

Source files
------------

// File: rtl/perip_laser_array.sv
// perip_laser_array
//   Memory-mapped laser-break peripheral. Each raw laser input is
//   synchronised and then debounced. A rising edge of the debounced level
//   on an enabled channel is latched in RISE and pushed as a rise mask into
//   an event FIFO. irq is raised while the FIFO holds entries or has
//   overflowed, if irq enable is set.
//
//   Register map (addr[4:0]):
//     0x00 LEVEL  R    [NCH-1:0] debounced levels
//     0x04 RISE   R/W1C [NCH-1:0] latched rises
//     0x08 CTRL   R/W  [NCH-1:0] rise enable mask, [31] irq enable
//     0x0C EVENT  R    {[31] valid, [NCH-1:0] mask}, a read pops the head
//     0x10 STAT   R/W  [6:0] FIFO count, [8] overflow (write 1 to clear)
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   d_in          bus write data
//   cs, rd, wr    select plus read/write strobes (both need cs)
//   addr          byte address, only [4:0] decoded
//   d_out         registered read data, holds when no read occurs
//   laser         asynchronous raw laser-break inputs
//   irq           registered level interrupt
module perip_laser_array #(
  parameter int NCH        = 4,
  parameter int DEB_CYCLES = 1000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     d_in,
  input  logic            cs,
  input  logic [31:0]     addr,
  input  logic            rd,
  input  logic            wr,
  output logic [31:0]     d_out,
  input  logic [NCH-1:0]  laser,
  output logic            irq
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [6:0]    DEPTH_CNT = 7'(FIFO_DEPTH);

  localparam logic [4:0] A_LEVEL = 5'h00;
  localparam logic [4:0] A_RISE  = 5'h04;
  localparam logic [4:0] A_CTRL  = 5'h08;
  localparam logic [4:0] A_EVENT = 5'h0C;
  localparam logic [4:0] A_STAT  = 5'h10;

  logic [NCH-1:0] sync1_r;
  logic [NCH-1:0] sync2_r;
  logic [NCH-1:0] level_r;
  logic [CW-1:0]  deb_cnt_r [NCH];
  logic [NCH-1:0] rise_r;
  logic [NCH-1:0] ctrl_en_r;
  logic           ctrl_irq_en_r;
  logic [NCH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]  wptr_r;
  logic [AW-1:0]  rptr_r;
  logic [6:0]     count_r;
  logic           ovf_r;

  logic [NCH-1:0] deb_hit_s;
  logic [NCH-1:0] rise_s;
  logic [NCH-1:0] w1c_s;
  logic [31:0]    rd_data_s;
  logic [4:0]     reg_addr_s;
  logic           rd_s;
  logic           wr_s;
  logic           push_s;
  logic           pop_s;
  logic           full_s;
  logic           push_ok_s;
  logic           ovf_set_s;
  logic           unused_s;

  assign reg_addr_s = addr[4:0];
  assign rd_s       = cs & rd;
  assign wr_s       = cs & wr;
  assign unused_s   = ^{addr[31:5], d_in};

  // A channel flips when it has disagreed for DEB_CYCLES samples, this one included.
  always_comb begin
    deb_hit_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if ((sync2_r[i] != level_r[i]) && (deb_cnt_r[i] == DEB_LAST)) begin
        deb_hit_s[i] = 1'b1;
      end else begin
        deb_hit_s[i] = 1'b0;
      end
    end
  end

  // A flip towards 1 is a 0->1 transition of the debounced level.
  assign rise_s    = deb_hit_s & sync2_r & ctrl_en_r;
  assign push_s    = |rise_s;
  assign pop_s     = rd_s && (reg_addr_s == A_EVENT) && (count_r != 7'd0);
  assign full_s    = (count_r == DEPTH_CNT);
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok_s = push_s && (!full_s || pop_s);
  assign ovf_set_s = push_s && full_s && !pop_s;

  // W1C mask for the RISE register.
  always_comb begin
    w1c_s = '0;
    if (wr_s && (reg_addr_s == A_RISE)) begin
      w1c_s = d_in[NCH-1:0];
    end else begin
      w1c_s = '0;
    end
  end

  // Read data mux for the addressed register.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (reg_addr_s)
      A_LEVEL: rd_data_s = 32'(level_r);
      A_RISE:  rd_data_s = 32'(rise_r);
      A_CTRL:  rd_data_s = {ctrl_irq_en_r, 31'(ctrl_en_r)};
      A_EVENT: begin
        if (count_r != 7'd0) begin
          rd_data_s = 32'h8000_0000 | 32'(fifo_mem_r[rptr_r]);
        end else begin
          rd_data_s = 32'h0000_0000;
        end
      end
      A_STAT:  rd_data_s = {23'd0, ovf_r, 1'b0, count_r};
      default: rd_data_s = 32'h0000_0000;
    endcase
  end

  // Two-flop synchroniser and per-channel debounce counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      level_r <= '0;
      for (int i = 0; i < NCH; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= laser;
      sync2_r <= sync1_r;
      for (int i = 0; i < NCH; i++) begin
        if (sync2_r[i] != level_r[i]) begin
          if (deb_hit_s[i]) begin
            level_r[i]   <= sync2_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + CW'(1);
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  // RISE latch (new rise beats same-cycle W1C) and CTRL register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_r        <= '0;
      ctrl_en_r     <= '0;
      ctrl_irq_en_r <= 1'b0;
    end else begin
      rise_r <= (rise_r & ~w1c_s) | rise_s;
      if (wr_s && (reg_addr_s == A_CTRL)) begin
        ctrl_en_r     <= d_in[NCH-1:0];
        ctrl_irq_en_r <= d_in[31];
      end else begin
        ctrl_en_r     <= ctrl_en_r;
        ctrl_irq_en_r <= ctrl_irq_en_r;
      end
    end
  end

  // FIFO storage; contents are only meaningful below count_r, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wptr_r] <= rise_s;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= 7'd0;
      ovf_r   <= 1'b0;
    end else begin
      // Power-of-two depth: pointers wrap naturally at AW bits.
      if (push_ok_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 7'd1;
        2'b01:   count_r <= count_r - 7'd1;
        default: count_r <= count_r;
      endcase
      // A fresh overflow wins over a same-cycle clear.
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (wr_s && (reg_addr_s == A_STAT) && d_in[8]) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= 32'h0000_0000;
      irq   <= 1'b0;
    end else begin
      if (rd_s) begin
        d_out <= rd_data_s;
      end
      irq <= ctrl_irq_en_r && ((count_r != 7'd0) || ovf_r);
    end
  end

endmodule
